// File: rtl/benes_pkg.sv
// Shared constants, types and controller states for the 8x8 Benes network configuration path.
package benes_pkg;

  localparam int N_PORTS      = 8;
  localparam int N_STAGES     = 5;
  localparam int SW_PER_STAGE = 4;
  localparam int SW_TOTAL     = N_STAGES * SW_PER_STAGE;

  typedef logic [SW_PER_STAGE-1:0] stage_cfg_t;
  typedef logic [SW_TOTAL-1:0]     net_cfg_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/benes_cfg_ctrl.sv
// Shadow-buffered configuration writer for the Benes switch fabric: collects per-stage beats,
// drains the pipelined network on commit, then applies all switch settings in a single edge.
module benes_cfg_ctrl #(
  parameter int N_STAGES     = 5,
  parameter int SW_PER_STAGE = 4,
  parameter int PIPE_LAT     = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [2:0]                       cfg_stage,
  input  logic [SW_PER_STAGE-1:0]          cfg_bits,
  input  logic                             cfg_last,
  output logic [N_STAGES*SW_PER_STAGE-1:0] switch_set,
  output logic                             net_in_en,
  output logic                             cfg_done,
  output logic                             cfg_err,
  output logic                             busy
);

  import benes_pkg::*;

  localparam int           SW_ALL     = N_STAGES * SW_PER_STAGE;
  localparam int           CNT_W      = 4;
  localparam logic [3:0]   N_STAGES_W = 4'(N_STAGES);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(PIPE_LAT - 1);

  cfg_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SW_ALL-1:0]     shadow_q, shadow_d;
  logic [N_STAGES-1:0]   mask_q, mask_d;
  logic [SW_ALL-1:0]     switch_set_q, switch_set_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  stage_ok;

  assign stage_ok = ({1'b0, cfg_stage} < N_STAGES_W);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    mask_d       = mask_q;
    switch_set_d = switch_set_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (stage_ok) begin
            for (int s = 0; s < N_STAGES; s++) begin
              if (cfg_stage == 3'(s)) begin
                shadow_d[s*SW_PER_STAGE +: SW_PER_STAGE] = cfg_bits;
                mask_d[s]                                = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
          // The commit decision sees the mask with this beat already merged in.
          if (cfg_last && stage_ok) begin
            if (&mask_d) begin
              state_d = DRAIN;
              cnt_d   = DRAIN_INIT;
              mask_d  = '0;
            end else begin
              err_d    = 1'b1;
              mask_d   = '0;
              shadow_d = '0;
            end
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          switch_set_d = shadow_q;
          state_d      = IDLE;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      mask_q       <= '0;
      switch_set_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      switch_set_q <= switch_set_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign net_in_en  = (state_q == IDLE);
  assign busy       = (state_q == DRAIN);
  assign switch_set = switch_set_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_benes_cfg_ctrl.sv
// Directed bench for benes_cfg_ctrl: load, stall, incomplete commit, bad stage and reset mid-drain.
module tb_benes_cfg_ctrl;

  localparam int PIPE_LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_stage;
  logic [3:0]  cfg_bits;
  logic        cfg_last;
  logic [19:0] switch_set;
  logic        net_in_en;
  logic        cfg_done;
  logic        cfg_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  benes_cfg_ctrl #(.N_STAGES(5), .SW_PER_STAGE(4), .PIPE_LAT(PIPE_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_stage  (cfg_stage),
    .cfg_bits   (cfg_bits),
    .cfg_last   (cfg_last),
    .switch_set (switch_set),
    .net_in_en  (net_in_en),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a beat just after a rising edge and holds it until accepted; returns #1 after the accept edge.
  task automatic send(input logic [2:0] stage, input logic [3:0] bits, input logic last);
    logic ok;
    int   n;
    cfg_valid = 1'b1;
    cfg_stage = stage;
    cfg_bits  = bits;
    cfg_last  = last;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = cfg_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) check("send_timeout", 32'd1, 32'd0);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Counts falling edges until cfg_done is seen; the pulse is expected PIPE_LAT+1 negedges after the commit edge.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_done && n < 40);
    check(tag, n, PIPE_LAT + 1);
  endtask

  initial begin
    int   seen;
    logic [19:0] prev;
    rst = 1'b1; cfg_valid = 1'b0; cfg_stage = '0; cfg_bits = '0; cfg_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_switch_set", switch_set, 20'h0);
    check("rst_net_in_en", net_in_en, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;

    // Full load: commit edge T, drain for PIPE_LAT cycles, apply at T+PIPE_LAT
    send(3'd0, 4'h1, 1'b0);
    send(3'd1, 4'h2, 1'b0);
    send(3'd2, 4'h4, 1'b0);
    send(3'd3, 4'h8, 1'b0);
    send(3'd4, 4'hF, 1'b1);
    for (int k = 0; k < PIPE_LAT; k++) begin
      @(negedge clk);
      check("drain_net_in_en", net_in_en, 0);
      check("drain_busy", busy, 1);
      check("drain_switch_hold", switch_set, 20'h0);
      check("drain_no_done", cfg_done, 0);
    end
    @(negedge clk);
    check("load_switch_set", switch_set, 20'hF8421);
    check("load_done_pulse", cfg_done, 1);
    check("load_net_in_en", net_in_en, 1);
    @(negedge clk);
    check("load_done_single", cfg_done, 0);
    @(posedge clk); #1;

    // Stall: stage 0 beat held through the drain is accepted only once IDLE again
    send(3'd0, 4'h3, 1'b0);
    send(3'd1, 4'h3, 1'b0);
    send(3'd2, 4'h3, 1'b0);
    send(3'd3, 4'h3, 1'b0);
    send(3'd4, 4'h3, 1'b1);
    cfg_valid = 1'b1; cfg_stage = 3'd0; cfg_bits = 4'hA; cfg_last = 1'b0;
    @(negedge clk);
    check("stall_ready_low", cfg_ready, 0);
    send(3'd0, 4'hA, 1'b0);
    check("stall_applied_first", switch_set, 20'h33333);
    send(3'd1, 4'h5, 1'b0);
    send(3'd2, 4'h6, 1'b0);
    send(3'd3, 4'h7, 1'b0);
    send(3'd4, 4'h9, 1'b1);
    wait_done("stall_done_latency");
    check("stall_switch_set", switch_set, 20'h9765A);
    @(posedge clk); #1;

    // Incomplete commit: error pulse, switch_set untouched, mask emptied
    send(3'd0, 4'h1, 1'b0);
    send(3'd1, 4'h2, 1'b1);
    @(negedge clk);
    check("incomplete_err", cfg_err, 1);
    check("incomplete_idle", busy, 0);
    check("incomplete_keep", switch_set, 20'h9765A);
    @(negedge clk);
    check("incomplete_err_single", cfg_err, 0);
    @(posedge clk); #1;
    send(3'd2, 4'h1, 1'b0);
    send(3'd3, 4'h1, 1'b0);
    send(3'd4, 4'h1, 1'b1);
    @(negedge clk);
    check("empty_mask_err", cfg_err, 1);
    check("empty_mask_idle", busy, 0);
    check("empty_mask_keep", switch_set, 20'h9765A);
    @(posedge clk); #1;

    // Bad stage index, then a full load with stage 2 rewritten
    send(3'd6, 4'hF, 1'b0);
    @(negedge clk);
    check("bad_stage_err", cfg_err, 1);
    check("bad_stage_idle", busy, 0);
    @(posedge clk); #1;
    send(3'd0, 4'h1, 1'b0);
    send(3'd1, 4'h1, 1'b0);
    send(3'd2, 4'h3, 1'b0);
    send(3'd2, 4'hC, 1'b0);
    send(3'd3, 4'h0, 1'b0);
    send(3'd4, 4'h2, 1'b1);
    wait_done("rewrite_done_latency");
    check("rewrite_switch_set", switch_set, 20'h20C11);
    @(posedge clk); #1;

    // Reset two cycles into a drain aborts the apply
    prev = switch_set;
    check("pre_abort_nonzero", (prev != 20'h0), 1);
    send(3'd0, 4'hF, 1'b0);
    send(3'd1, 4'hF, 1'b0);
    send(3'd2, 4'hF, 1'b0);
    send(3'd3, 4'hF, 1'b0);
    send(3'd4, 4'hF, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_switch_set", switch_set, 20'h0);
    check("abort_net_in_en", net_in_en, 1);
    check("abort_busy", busy, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cfg_done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_switch_stays", switch_set, 20'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
